// File: rtl/dp_pkg.sv
// Shared definitions for the drain mux slice.
//   drain_state_t : drain FSM states
//   DP_BW         : default group result / output bus width
//   DP_N_GROUPS   : default number of SMAC groups
package dp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } drain_state_t;

    localparam int DP_BW       = 128;
    localparam int DP_N_GROUPS = 4;

endpackage

// File: rtl/dp_drain_mux_if.sv
// Bus between the SMAC array / writeback path and dp_drain_mux.
//   start, grp_mask, in_from_smacs : snapshot request side
//   out_data/out_grp/out_last/out_valid/out_ready : drain beat handshake
//   busy, done : drain status
// master = the drain mux itself, slave = its environment.
interface dp_drain_mux_if
    import dp_pkg::*;
#(
    parameter int BW       = DP_BW,
    parameter int N_GROUPS = DP_N_GROUPS
);
    localparam int SEL_W = $clog2(N_GROUPS);

    logic                   start;
    logic [N_GROUPS-1:0]    grp_mask;
    logic [N_GROUPS*BW-1:0] in_from_smacs;
    logic [BW-1:0]          out_data;
    logic [SEL_W-1:0]       out_grp;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   done;

    modport master (
        input  start, grp_mask, in_from_smacs, out_ready,
        output out_data, out_grp, out_last, out_valid, busy, done
    );

    modport slave (
        output start, grp_mask, in_from_smacs, out_ready,
        input  out_data, out_grp, out_last, out_valid, busy, done
    );
endinterface

// File: rtl/dp_prio_enc.sv
// Lowest-set-bit priority encoder.
//   mask   : request vector
//   idx    : index of the lowest set bit (0 when mask is empty)
//   onehot : exactly one bit of mask is set
//   any    : at least one bit of mask is set
module dp_prio_enc #(
    parameter int N = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    output logic [SEL_W-1:0] idx,
    output logic             onehot,
    output logic             any
);
    always_comb begin
        idx = '0;
        // Scan downwards so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) idx = SEL_W'(i);
        end
    end

    assign any    = |mask;
    // Clearing the lowest set bit leaves nothing when only one was set.
    assign onehot = any && ((mask & (mask - {{(N-1){1'b0}}, 1'b1})) == '0);
endmodule

// File: rtl/dp_drain_mux.sv
// Snapshots N_GROUPS SMAC result words on start, then drains the groups
// selected by grp_mask onto one BW-wide bus in ascending group order.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dp_drain_mux_if master (request, beat handshake, status)
module dp_drain_mux
    import dp_pkg::*;
#(
    parameter int BW       = DP_BW,
    parameter int N_GROUPS = DP_N_GROUPS
) (
    input  logic           clk,
    input  logic           rst,
    dp_drain_mux_if.master bus
);
    localparam int SEL_W = $clog2(N_GROUPS);

    drain_state_t                   state, state_nxt;
    logic [N_GROUPS-1:0][BW-1:0]    snap, snap_nxt;
    logic [N_GROUPS-1:0]            rem_mask, rem_nxt, clr_mask;
    logic [SEL_W-1:0]               nxt_idx;
    logic                           nxt_onehot, nxt_any;
    logic                           xfer;

    assign xfer = bus.out_valid && bus.out_ready;

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem_mask;
        snap_nxt  = snap;
        clr_mask  = '0;
        clr_mask[bus.out_grp] = 1'b1;
        case (state)
            IDLE: if (bus.start) begin
                snap_nxt  = bus.in_from_smacs;
                rem_nxt   = bus.grp_mask;
                state_nxt = (bus.grp_mask != '0) ? SEND : DONE;
            end
            SEND: if (xfer) begin
                rem_nxt = rem_mask & ~clr_mask;
                if (bus.out_last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decode the mask that will be live next cycle so every beat field
    // comes straight out of a flop.
    dp_prio_enc #(.N(N_GROUPS)) u_enc (
        .mask   (rem_nxt),
        .idx    (nxt_idx),
        .onehot (nxt_onehot),
        .any    (nxt_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            snap          <= '0;
            rem_mask      <= '0;
            bus.out_data  <= '0;
            bus.out_grp   <= '0;
            bus.out_last  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_nxt;
            snap          <= snap_nxt;
            rem_mask      <= rem_nxt;
            bus.out_valid <= (state_nxt == SEND) && nxt_any;
            bus.out_data  <= (state_nxt == SEND) ? snap_nxt[nxt_idx] : '0;
            bus.out_grp   <= (state_nxt == SEND) ? nxt_idx : '0;
            bus.out_last  <= (state_nxt == SEND) && nxt_onehot;
            bus.busy      <= (state_nxt != IDLE);
            bus.done      <= (state_nxt == DONE);
        end
    end
endmodule

// File: tb/tb_dp_drain_mux.sv
module tb_dp_drain_mux;
    localparam int BW  = 128;
    localparam int NG  = 4;
    localparam int BWB = 64;
    localparam int NGB = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dp_drain_mux_if #(.BW(BW),  .N_GROUPS(NG))  ifa ();
    dp_drain_mux_if #(.BW(BWB), .N_GROUPS(NGB)) ifb ();

    dp_drain_mux #(.BW(BW),  .N_GROUPS(NG))  u_a (.clk(clk), .rst(rst), .bus(ifa));
    dp_drain_mux #(.BW(BWB), .N_GROUPS(NGB)) u_b (.clk(clk), .rst(rst), .bus(ifb));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model for the 4-group instance: a queue of groups still to
    // send, the captured words, and a pending done cycle.
    logic [BW-1:0] msnap [NG];
    int            q[$];
    bit            mdone;

    task automatic model_reset();
        q.delete();
        mdone = 1'b0;
        for (int i = 0; i < NG; i++) msnap[i] = '0;
    endtask

    task automatic model_edge();
        if (q.size() > 0) begin
            if (ifa.out_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) mdone = 1'b1;
            end
        end else if (mdone) begin
            mdone = 1'b0;
        end else if (ifa.start) begin
            for (int i = 0; i < NG; i++) begin
                msnap[i] = ifa.in_from_smacs[i*BW +: BW];
                if (ifa.grp_mask[i]) q.push_back(i);
            end
            mdone = (q.size() == 0);
        end
    endtask

    task automatic cmp_a();
        bit v;
        v = (q.size() > 0);
        chk("a_valid", ifa.out_valid, v);
        chk("a_busy",  ifa.busy, v || mdone);
        chk("a_done",  ifa.done, mdone);
        if (v) begin
            chk("a_data", ifa.out_data, msnap[q[0]]);
            chk("a_grp",  ifa.out_grp,  q[0]);
            chk("a_last", ifa.out_last, q.size() == 1);
        end
    endtask

    task automatic step_a();
        @(posedge clk);
        model_edge();
        #1;
        cmp_a();
    endtask

    function automatic logic [NG*BW-1:0] rnd_flat();
        logic [NG*BW-1:0] r;
        for (int k = 0; k < NG*BW/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [NG*BW-1:0] pat_flat();
        logic [NG*BW-1:0] r;
        for (int i = 0; i < NG; i++) r[i*BW +: BW] = {16{8'(8'hA0 + 8'h11 * i)}};
        return r;
    endfunction

    function automatic logic [BWB-1:0] bword(input int i);
        return {8{8'(8'h10 + i)}};
    endfunction

    function automatic logic [NGB*BWB-1:0] bflat();
        logic [NGB*BWB-1:0] r;
        for (int i = 0; i < NGB; i++) r[i*BWB +: BWB] = bword(i);
        return r;
    endfunction

    // One drain: mask, out_ready per cycle after the start edge (bit c-1 for
    // cycle c, 1 afterwards), expected transfers, cycle of done, and the
    // expected group of each transfer (2 bits per slot).
    typedef struct {
        logic [3:0] mask;
        logic [7:0] rdy;
        int         xfers;
        int         done_cyc;
        logic [7:0] grps;
    } vec_t;

    vec_t vt [6];

    task automatic run_vec(input vec_t v, input bit pattern);
        int xf;
        int dc;
        xf = 0;
        dc = 0;
        ifa.grp_mask      = v.mask;
        ifa.in_from_smacs = pattern ? pat_flat() : rnd_flat();
        ifa.start         = 1'b1;
        step_a();
        // A competing start with another mask while busy, and the source
        // words overwritten right after the snapshot.
        ifa.grp_mask      = ~v.mask;
        ifa.in_from_smacs = '1;
        for (int c = 1; c <= 20; c++) begin
            ifa.out_ready = (c <= 8) ? v.rdy[c-1] : 1'b1;
            if (ifa.done) begin
                dc = c;
            end else if (ifa.out_valid && ifa.out_ready) begin
                if (xf < 4) chk("vec_grp", ifa.out_grp, v.grps[2*xf +: 2]);
                xf++;
            end
            if (c > 1) ifa.in_from_smacs = rnd_flat();
            step_a();
            if (c == 1) ifa.start = 1'b0;
            if (dc != 0) break;
        end
        chk("vec_xfers", xf, v.xfers);
        chk("vec_done_cycle", dc, v.done_cyc);
    endtask

    task automatic exp_b(input string tag, input logic v, input int g, input logic [BWB-1:0] d,
                         input logic l, input logic bz, input logic dn);
        chk({tag, "_valid"}, ifb.out_valid, v);
        chk({tag, "_busy"},  ifb.busy, bz);
        chk({tag, "_done"},  ifb.done, dn);
        if (v) begin
            chk({tag, "_grp"},  ifb.out_grp, g);
            chk({tag, "_data"}, ifb.out_data, d);
            chk({tag, "_last"}, ifb.out_last, l);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{4'b1111, 8'hFF,        4, 5, 8'hE4};
        vt[1] = '{4'b1010, 8'b1111_0010, 2, 6, 8'h0D};
        vt[2] = '{4'b0000, 8'hFF,        0, 1, 8'h00};
        vt[3] = '{4'b1000, 8'b1111_1100, 1, 4, 8'h03};
        vt[4] = '{4'b0110, 8'b1111_1101, 2, 4, 8'h09};
        vt[5] = '{4'b1001, 8'hFF,        2, 3, 8'h0C};

        rst = 1'b1;
        ifa.start = 1'b0; ifa.grp_mask = '0; ifa.in_from_smacs = '0; ifa.out_ready = 1'b0;
        ifb.start = 1'b0; ifb.grp_mask = '0; ifb.in_from_smacs = '0; ifb.out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", ifa.out_valid, 1'b0);
        chk("rst_busy",  ifa.busy, 1'b0);
        chk("rst_done",  ifa.done, 1'b0);
        chk("rst_data",  ifa.out_data, '0);
        chk("rst_grp",   ifa.out_grp, '0);
        chk("rst_last",  ifa.out_last, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step_a();

        for (int v = 0; v < 6; v++) run_vec(vt[v], v == 0);

        // Reset while the second beat is on the bus.
        ifa.grp_mask = 4'hF; ifa.in_from_smacs = rnd_flat(); ifa.out_ready = 1'b1;
        ifa.start = 1'b1;
        step_a();
        ifa.start = 1'b0;
        step_a();
        chk("mid_rst_grp_before", ifa.out_grp, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", ifa.out_valid, 1'b0);
        chk("mid_rst_busy",  ifa.busy, 1'b0);
        chk("mid_rst_done",  ifa.done, 1'b0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        step_a();
        step_a();
        run_vec(vt[0], 1'b1);

        // Random traffic, spurious starts included.
        for (int n = 0; n < 1500; n++) begin
            ifa.start         = ($urandom % 3) == 0;
            ifa.grp_mask      = 4'($urandom);
            ifa.in_from_smacs = rnd_flat();
            ifa.out_ready     = ($urandom % 4) != 0;
            step_a();
        end
        ifa.start = 1'b0;

        // 8-group, 64-bit instance: mask 1000_0001.
        ifb.grp_mask = 8'b1000_0001; ifb.in_from_smacs = bflat(); ifb.out_ready = 1'b1;
        ifb.start = 1'b1;
        @(posedge clk); #1;
        ifb.start = 1'b0; ifb.in_from_smacs = '1;
        exp_b("b1_c1", 1'b1, 0, bword(0), 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        exp_b("b1_c2", 1'b1, 7, bword(7), 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        exp_b("b1_c3", 1'b0, 0, '0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        exp_b("b1_c4", 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);

        // Reset during a stalled drain, then a fresh drain.
        ifb.in_from_smacs = bflat(); ifb.out_ready = 1'b0; ifb.start = 1'b1;
        @(posedge clk); #1;
        ifb.start = 1'b0;
        exp_b("b2_c1", 1'b1, 0, bword(0), 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        exp_b("b2_stall", 1'b1, 0, bword(0), 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp_b("b2_rst", 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        exp_b("b2_idle", 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
        ifb.grp_mask = 8'b0100_0010; ifb.out_ready = 1'b1; ifb.start = 1'b1;
        @(posedge clk); #1;
        ifb.start = 1'b0;
        exp_b("b3_c1", 1'b1, 1, bword(1), 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        exp_b("b3_c2", 1'b1, 6, bword(6), 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        exp_b("b3_c3", 1'b0, 0, '0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        exp_b("b3_c4", 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dp_drain_mux.md
Name: dp_drain_mux

Overview:
- Parametrised successor to the four-way SMAC output selector.
- Snapshots N_GROUPS SMAC group result words on a start pulse, then drains the groups selected by a mask onto a single BW-wide output bus with a valid/ready handshake.
- Beats go out in ascending group order, tagged with the group index and a last flag.
- Sits between the SMAC array and the datapath writeback path, so the SMACs can start new work while results drain.

Parameters:
- BW, 128, width of one group result word and of the output bus
- N_GROUPS, 4, number of SMAC groups (>=2)
- SEL_W, $clog2(N_GROUPS), width of the group index (derived; not overridden)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to snapshot and drain
- grp_mask  input  N_GROUPS  groups to drain; bit i set means group i is drained; sampled with start
- in_from_smacs  input  N_GROUPS*BW  flattened group results; group i occupies bits [i*BW +: BW]
- out_data  output  BW  current beat data (registered)
- out_grp  output  SEL_W  group index of the current beat
- out_last  output  1  current beat is the final one of the drain
- out_valid  output  1  beat available
- out_ready  input  1  downstream accepts the beat
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the drain completes

Behaviour:
- Reset (async assert, sync release): state IDLE; out_data, out_grp, out_last, out_valid, busy, done all 0; snapshot and remaining-mask registers 0.
- States:
  - IDLE: start=1 is accepted.
    - On that edge, all N_GROUPS inputs are copied to the snapshot registers and grp_mask is copied to rem_mask.
    - Nonzero mask: go to SEND.
    - Zero mask: go to DONE.
  - SEND: out_valid=1, busy=1.
    - Current group is idx = lowest set bit of rem_mask; out_data = snapshot[idx], out_grp = idx.
    - out_last = 1 when rem_mask has exactly one bit set.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge t. First beat is valid in cycle t+1. Zero mask gives done in cycle t+1.
- Handshake:
  - A beat transfers on a rising edge with out_valid && out_ready.
  - On transfer, bit idx of rem_mask is cleared. The next beat is presented in the following cycle with no bubble.
  - If the transferred beat had out_last=1, go to DONE.
  - While out_valid && !out_ready, out_data, out_grp and out_last hold stable.
  - out_valid never drops without a transfer, except on reset.
- Throughput: with out_ready held high, k masked groups take k cycles plus 1 done cycle. A new start is accepted in the cycle after done, at the earliest.
- start outside IDLE (SEND or DONE) is ignored; the snapshot and mask are unchanged.
- in_from_smacs changes after the snapshot edge do not affect output data.
- Output registers are updated from the next-state rem_mask, so outputs are glitch-free registers, not combinational decode.
- Reset mid-drain: everything clears immediately and out_valid=0. Remaining beats are discarded and no done pulse is issued.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package dp_pkg holds:
  - the state enum drain_state_t {IDLE, SEND, DONE}
  - default constants DP_BW=128 and DP_N_GROUPS=4
- Sub-module dp_prio_enc, parametrised on N, returns:
  - the lowest-set-bit index (SEL_W bits)
  - a one-hot flag (exactly one bit set)
  - an any flag
- It is instantiated once on the next-state rem_mask.

Test Plan:
- Reset, then start with grp_mask=4'b1111, groups = 0xA0..,0xB1..,0xC2..,0xD3.., out_ready=1 -> four beats on consecutive cycles from t+1, out_grp 0,1,2,3; out_last only on grp 3; done pulse in cycle t+5; busy low at t+6.
- grp_mask=4'b1010 with out_ready toggling 0,1,0,0,1 -> only groups 1 and 3 emitted; data, grp and last stable during stalls; exactly 2 transfers; done one cycle after the second transfer.
- Start, then change in_from_smacs to all-ones the next cycle -> emitted data equals the pre-change snapshot.
- grp_mask=0 -> no out_valid; done=1 in cycle t+1; back to IDLE at t+2.
- Second start issued during SEND with a different mask and data -> ignored; beats follow the first mask; a start in the cycle after done is accepted.
- Assert rst during SEND at the second beat -> out_valid, busy and done are 0 immediately; no done pulse; a fresh start afterwards drains correctly. Repeat with N_GROUPS=8, BW=64, mask 8'b1000_0001 -> beats grp 0 then grp 7.
